// File: rtl/cr_pkg.sv
// cr_pkg: shared types and constants for cr_gen_fifo_disp.
// Holds the generator mode enum, the hex to 7-segment table,
// and the maximal-length Galois LFSR tap lookup.
package cr_pkg;

    // Generator flavour selected at elaboration time.
    typedef enum logic [0:0] {
        GEN_CNT  = 1'b0,
        GEN_LFSR = 1'b1
    } gen_mode_e;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Right-shift Galois feedback mask: bit (t-1) set for every tap t of a
    // primitive polynomial, so the sequence visits all 2^w-1 non-zero states.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/cr_sevenseg_scan.sv
// cr_sevenseg_scan: multiplexed N_DIG-digit hex display driver.
// Shows the low 4*N_DIG bits of the display word (zero-extended when the
// word is narrower), one digit per SCAN_DIV clocks. ss and dig are both
// registered and update on the same edge, so digits never glitch.
// msd_f forces the leftmost digit to "F" (used as an overflow marker).
module cr_sevenseg_scan
    import cr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] disp,
    input  logic              msd_f,
    output logic [6:0]        ss,
    output logic [N_DIG-1:0]  dig
);

    localparam int VW = 4 * N_DIG;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    logic [VW-1:0]    disp_ext;
    logic [SW-1:0]    scan_cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic             slot_end;
    logic [3:0]       nib;
    logic [6:0]       ss_nxt;
    logic [N_DIG-1:0] dig_nxt;

    // Fit the display word to exactly N_DIG nibbles.
    generate
        if (DATA_W >= VW) begin : g_trunc
            assign disp_ext = disp[VW-1:0];
        end else begin : g_zext
            assign disp_ext = {{(VW - DATA_W){1'b0}}, disp};
        end
    endgenerate

    // Next digit index plus the segment/select pattern for that digit.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        slot_end = (scan_cnt == SCAN_LAST);
        idx_nxt  = idx;
        nib      = 4'h0;
        dig_nxt  = '1;
        if (slot_end) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
        for (int d = 0; d < N_DIG; d++) begin
            if (idx_nxt == IW'(d)) begin
                nib        = disp_ext[4*d +: 4];
                dig_nxt[d] = 1'b0;
            end
        end
        ss_nxt = SEG_TABLE[nib];
        if (msd_f && (idx_nxt == IDX_LAST)) begin
            ss_nxt = SEG_TABLE[4'hF];
        end
    end

    // Scan timer, digit index and the registered display outputs.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            scan_cnt <= '0;
            idx      <= '0;
            dig      <= ~N_DIG'(1);
            ss       <= SEG_TABLE[4'h0];
        end else begin
            scan_cnt <= slot_end ? '0 : scan_cnt + SW'(1);
            idx      <= idx_nxt;
            dig      <= dig_nxt;
            ss       <= ss_nxt;
        end
    end

endmodule

// File: rtl/cr_gen_fifo_disp.sv
// cr_gen_fifo_disp: data generator -> FIFO -> hex display core.
// A counter or Galois LFSR pushes words into a DEPTH-deep FIFO; pops copy
// the head word into a display register shown on a multiplexed 7-segment
// display. Push/pop qualify once per TICK_DIV clocks while ENwrk is high.
// Optional build macro CR_OVF_FLAG_EN adds a sticky `ovf` output that is
// set on any dropped write and marks the leftmost digit with "F".
module cr_gen_fifo_disp
    import cr_pkg::*;
#(
    parameter int        DATA_W   = 8,
    parameter int        DEPTH    = 8,
    parameter int        N_DIG    = 4,
    parameter gen_mode_e GEN_MODE = GEN_CNT,
    parameter int        TICK_DIV = 1,
    parameter int        SCAN_DIV = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENgen,
    input  logic                  ENwrk,
    input  logic                  ENraf,
    output logic [$clog2(DEPTH):0] usedw,
    output logic [6:0]            ss,
    output logic [N_DIG-1:0]      dig
`ifdef CR_OVF_FLAG_EN
    ,
    output logic                  ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DATA_W-1:0] TAPS      = DATA_W'(lfsr_taps(DATA_W));
    // The LFSR must never start in (or reach) the all-zero lock-up state.
    localparam logic [DATA_W-1:0] GEN_RESET =
        (GEN_MODE == GEN_LFSR) ? DATA_W'(1) : DATA_W'(0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     pre;
    logic [DATA_W-1:0] gen_q;
    logic [DATA_W-1:0] gen_nxt;
    logic [DATA_W-1:0] disp_q;
    logic              tick;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              msd_f;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign tick  = ENwrk && (pre == TICK_LAST);
    // A pop in the same tick frees a slot, so a full FIFO can still accept.
    assign pop   = tick && ENraf && !empty;
    assign push  = tick && ENgen && (!full || pop);
    assign usedw = cnt;

    // Prescaler: free-runs while ENwrk is high, frozen otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre <= '0;
        end else if (ENwrk) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // Next generator value: counter increment or one Galois LFSR step.
    always_comb begin
        gen_nxt = gen_q + DATA_W'(1);
        if (GEN_MODE == GEN_LFSR) begin
            gen_nxt = (gen_q >> 1) ^ (gen_q[0] ? TAPS : '0);
        end
    end

    // FIFO pointers, occupancy, generator and display register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            gen_q  <= GEN_RESET;
            disp_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                gen_q  <= gen_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                disp_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; its contents are unreadable
        // until written because the pointers and count are reset instead.
        if (push && !RST) begin
            mem[wr_ptr] <= gen_q;
        end
    end

`ifdef CR_OVF_FLAG_EN
    logic drop;
    assign drop  = tick && ENgen && full && !pop;
    assign msd_f = ovf;

    // Sticky overflow flag: set by any dropped write, cleared only by RST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`else
    assign msd_f = 1'b0;
`endif

    cr_sevenseg_scan #(
        .DATA_W   (DATA_W),
        .N_DIG    (N_DIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .CLK   (CLK),
        .RST   (RST),
        .disp  (disp_q),
        .msd_f (msd_f),
        .ss    (ss),
        .dig   (dig)
    );

endmodule

// File: tb/tb_cr_gen_fifo_disp.sv
// tb_cr_gen_fifo_disp: self-checking bench for cr_gen_fifo_disp.
// u0: counter FIFO core driven from a vector table.
// u1: LFSR generator with TICK_DIV=4.
// u2: 16-bit word on a 4-digit display with SCAN_DIV=4.
`timescale 1ns/1ps
module tb_cr_gen_fifo_disp;
    import cr_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic       rst0, engen0, enwrk0, enraf0;
    logic [3:0] usedw0;
    logic [6:0] ss0;
    logic [1:0] dig0;

    logic       rst1, engen1, enwrk1, enraf1;
    logic [3:0] usedw1;
    logic [6:0] ss1;
    logic [1:0] dig1;

    logic       rst2, engen2, enwrk2, enraf2;
    logic [3:0] usedw2;
    logic [6:0] ss2;
    logic [3:0] dig2;

`ifdef CR_OVF_FLAG_EN
    logic ovf0, ovf1, ovf2;
`endif

    cr_gen_fifo_disp #(.DATA_W(8), .DEPTH(8), .N_DIG(2), .GEN_MODE(GEN_CNT),
                       .TICK_DIV(1), .SCAN_DIV(2)) u0 (
        .CLK(CLK), .RST(rst0), .ENgen(engen0), .ENwrk(enwrk0), .ENraf(enraf0),
        .usedw(usedw0), .ss(ss0), .dig(dig0)
`ifdef CR_OVF_FLAG_EN
        , .ovf(ovf0)
`endif
    );

    cr_gen_fifo_disp #(.DATA_W(8), .DEPTH(8), .N_DIG(2), .GEN_MODE(GEN_LFSR),
                       .TICK_DIV(4), .SCAN_DIV(2)) u1 (
        .CLK(CLK), .RST(rst1), .ENgen(engen1), .ENwrk(enwrk1), .ENraf(enraf1),
        .usedw(usedw1), .ss(ss1), .dig(dig1)
`ifdef CR_OVF_FLAG_EN
        , .ovf(ovf1)
`endif
    );

    cr_gen_fifo_disp #(.DATA_W(16), .DEPTH(8), .N_DIG(4), .GEN_MODE(GEN_CNT),
                       .TICK_DIV(1), .SCAN_DIV(4)) u2 (
        .CLK(CLK), .RST(rst2), .ENgen(engen2), .ENwrk(enwrk2), .ENraf(enraf2),
        .usedw(usedw2), .ss(ss2), .dig(dig2)
`ifdef CR_OVF_FLAG_EN
        , .ovf(ovf2)
`endif
    );

    typedef struct {
        logic       rst;
        logic       engen;
        logic       enwrk;
        logic       enraf;
        logic [3:0] usedw;
        logic [7:0] disp;
        logic [7:0] gen;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic r, input logic g, input logic w, input logic f,
                       input int u, input int d, input int n, input logic o);
        vec_t v;
        v.rst   = r;
        v.engen = g;
        v.enwrk = w;
        v.enraf = f;
        v.usedw = 4'(u);
        v.disp  = 8'(d);
        v.gen   = 8'(n);
        v.ovf   = o;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        logic [7:0] got;
        logic       seen [256];
        int         distinct;
        logic       ok_a, ok_b;
        logic [3:0] dexp [4];
        logic [6:0] sexp [4];

        rst0 = 1; engen0 = 0; enwrk0 = 0; enraf0 = 0;
        rst1 = 1; engen1 = 0; enwrk1 = 0; enraf1 = 0;
        rst2 = 1; engen2 = 0; enwrk2 = 0; enraf2 = 0;
        repeat (2) step();

        // Reset state of all three instances.
        check("rst_usedw0", usedw0, 0);
        check("rst_dig0", dig0, 2'b10);
        check("rst_ss0", ss0, 7'h40);
        check("rst_gen_lfsr", u1.gen_q, 8'h01);
        check("rst_dig2", dig2, 4'b1110);
        check("rst_ss2", ss2, 7'h40);

        // ---- u0 vector table: rst, ENgen, ENwrk, ENraf -> usedw, disp, gen, ovf
        // Fill to full, then two dropped writes.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 1, 0, i, 0, i, 0);
        add(0, 1, 1, 0, 8, 0, 8, 1);
        add(0, 1, 1, 0, 8, 0, 8, 1);
        // Drain: pops 0..7, then an empty pop is ignored.
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 1, 8 - k, k - 1, 8, 1);
        add(0, 0, 1, 1, 0, 7, 8, 1);
        // ENwrk low blocks everything.
        add(0, 1, 0, 1, 0, 7, 8, 1);
        // Refill, then push+pop while full keeps usedw at 8.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 1, 0, i, 0, i, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 1, 1, 8, k - 1, 8 + k, 0);
        // Reset mid-operation discards the in-flight push/pop.
        add(1, 1, 1, 1, 0, 0, 0, 0);
        // Empty with push+pop: only the push happens.
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0, 1, 0, 2, 0);
        add(0, 0, 1, 1, 0, 1, 2, 0);

        rst1 = 0;
        rst2 = 0;
        foreach (vecs[i]) begin
            rst0   = vecs[i].rst;
            engen0 = vecs[i].engen;
            enwrk0 = vecs[i].enwrk;
            enraf0 = vecs[i].enraf;
            step();
            check($sformatf("vec%0d_usedw", i), usedw0, vecs[i].usedw);
            check($sformatf("vec%0d_disp", i), u0.disp_q, vecs[i].disp);
            check($sformatf("vec%0d_gen", i), u0.gen_q, vecs[i].gen);
`ifdef CR_OVF_FLAG_EN
            check($sformatf("vec%0d_ovf", i), ovf0, vecs[i].ovf);
`endif
        end
        rst0 = 0; engen0 = 0; enwrk0 = 0; enraf0 = 0;

        // ---- u1: prescaler with TICK_DIV=4 (u1 idle since reset, prescaler 0)
        enwrk1 = 1; engen1 = 1; enraf1 = 0;
        repeat (3) step();
        check("pre_no_tick", usedw1, 0);
        step();
        check("pre_tick", usedw1, 1);
        check("lfsr_step1", u1.gen_q, 8'hB8);
        repeat (2) step();
        enwrk1 = 0;
        repeat (5) step();
        check("pre_frozen", usedw1, 1);
        enwrk1 = 1;
        step();
        check("pre_resume", usedw1, 1);
        step();
        check("pre_tick2", usedw1, 2);

        // ---- u1: full LFSR period through the FIFO with concurrent pops.
        enraf1 = 1;
        m = 8'h01;
        distinct = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int j = 0; j < 256; j++) begin
            repeat (4) step();
            got = u1.disp_q;
            if (j < 255) begin
                check("lfsr_seq", got, m);
                if (got != 8'h00 && !seen[got]) distinct++;
                seen[got] = 1'b1;
            end else begin
                check("lfsr_wrap", got, 8'h01);
            end
            m = (m >> 1) ^ (m[0] ? 8'hB8 : 8'h00);
        end
        check("lfsr_distinct", distinct, 255);
        check("lfsr_usedw", usedw1, 2);
        engen1 = 0; enraf1 = 0; enwrk1 = 0;

        // ---- u2: load 0x3A5C into the display register via push+pop stream.
        engen2 = 1; enwrk2 = 1; enraf2 = 1;
        repeat (16'h3A5E) step();
        engen2 = 0; enraf2 = 0;
        check("disp_load", u2.disp_q, 16'h3A5C);
        check("disp_usedw", usedw2, 1);

        // Align to the first clock of digit 0 (bounded waits).
        ok_a = 0;
        for (int i = 0; i < 40 && !ok_a; i++) begin
            if (dig2 != 4'b1110) ok_a = 1; else step();
        end
        ok_b = 0;
        for (int i = 0; i < 40 && !ok_b; i++) begin
            if (dig2 == 4'b1110) ok_b = 1; else step();
        end
        check("scan_sync", {31'd0, ok_a & ok_b}, 1);

        dexp[0] = 4'b1110; sexp[0] = 7'h46;  // C
        dexp[1] = 4'b1101; sexp[1] = 7'h12;  // 5
        dexp[2] = 4'b1011; sexp[2] = 7'h08;  // A
        dexp[3] = 4'b0111; sexp[3] = 7'h30;  // 3
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_dig_s%0d_c%0d", s, c), dig2, dexp[s]);
                check($sformatf("scan_ss_s%0d_c%0d", s, c), ss2, sexp[s]);
                step();
            end
        end

        // Reset in the middle of digit 1.
        repeat (5) step();
        check("pre_rst_dig", dig2, 4'b1101);
        rst2 = 1;
        step();
        check("mid_rst_dig", dig2, 4'b1110);
        check("mid_rst_ss", ss2, 7'h40);
        check("mid_rst_usedw", usedw2, 0);
        check("mid_rst_disp", u2.disp_q, 16'h0000);
        rst2 = 0;

`ifdef CR_OVF_FLAG_EN
        check("ovf1_clear", ovf1, 0);
        check("ovf2_clear", ovf2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
